synth_pwm_stream: RTL and testbench

- Downstream consumer of the synth sample stream, driving the audio PWM pin.
- Issues one-cycle `sample_ready` request pulses to the synth and captures each returned 14-bit sample on `sample_valid`.
- Buffers captured samples in a small FIFO.
- Drains one sample per PWM period into a registered duty cycle that drives the `pwm` output.

---
 rtl/synth_pwm_stream_if.sv | 11 +
 rtl/synth_pwm_stream.sv | 153 +++++++++++++++
 tb/tb_synth_pwm_stream.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/synth_pwm_stream_if.sv
// Sample request/response link between the synth (master) and the PWM stream consumer (slave).
interface synth_pwm_stream_if #(
  parameter int SAMPLE_W = 14
);
  logic                sample_ready;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;

  modport master (input sample_ready, output sample_valid, output sample);
  modport slave  (output sample_ready, input sample_valid, input sample);
endinterface

// File: rtl/synth_pwm_stream.sv
// Synth sample consumer: requests samples, buffers them in a FIFO and plays them out as PWM duty.
// Optional build macro SYNTH_PWM_UNDERFLOW_MUTE_EN loads midscale duty on an underflow period.
module synth_pwm_stream #(
  parameter int SAMPLE_W    = 14,
  parameter int PWM_W       = 10,
  parameter int FIFO_DEPTH  = 4,
  parameter int REQ_TIMEOUT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  synth_pwm_stream_if.slave             s_if,
  output logic                          pwm,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    underflow_cnt,
  output logic                          req_timeout_err
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int TO_W  = (REQ_TIMEOUT > 1) ? $clog2(REQ_TIMEOUT) : 1;

  localparam logic [PWM_W-1:0] CNT_MAX  = '1;
  localparam logic [PWM_W-1:0] DUTY_MID = {1'b1, {(PWM_W-1){1'b0}}};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Offset-binary conversion of the top PWM_W sample bits; the LSBs are simply dropped.
  function automatic logic [PWM_W-1:0] to_duty(input logic [PWM_W-1:0] top);
    return {~top[PWM_W-1], top[PWM_W-2:0]};
  endfunction

  logic [0:0]       state;
  logic [TO_W-1:0]  tmo_cnt;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [PWM_W-1:0] mem [FIFO_DEPTH];
  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] duty;

  logic             push;
  logic             pop;
  logic             timeout;
  logic             boundary;
  logic             fifo_empty;
  logic             req_free;
  logic             issue;
  logic [LVL_W:0]   level_after_push;

  generate
    if (SAMPLE_W > PWM_W) begin : g_lsb
      logic unused_sample_lsbs;
      assign unused_sample_lsbs = ^s_if.sample[SAMPLE_W-PWM_W-1:0];
    end
  endgenerate

  assign push       = (state == ST_WAIT) && s_if.sample_valid;
  assign timeout    = (state == ST_WAIT) && !s_if.sample_valid &&
                      (tmo_cnt == TO_W'(REQ_TIMEOUT - 1));
  assign boundary   = (pwm_cnt == CNT_MAX);
  assign fifo_empty = (fifo_level == '0);
  assign pop        = boundary && !fifo_empty;

  // A response or timeout frees the request slot in the same cycle, so pulses can be 2 cycles apart.
  assign req_free         = (state == ST_IDLE) || push || timeout;
  assign level_after_push = {1'b0, fifo_level} + {{LVL_W{1'b0}}, push};
  assign issue            = req_free && enable &&
                            (level_after_push < (LVL_W+1)'(FIFO_DEPTH));

  // Request FSM: one outstanding request, registered one-cycle sample_ready pulse.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      tmo_cnt           <= '0;
      s_if.sample_ready <= 1'b0;
      req_timeout_err   <= 1'b0;
    end else begin
      if (issue) begin
        state             <= ST_WAIT;
        tmo_cnt           <= '0;
        s_if.sample_ready <= 1'b1;
      end else begin
        s_if.sample_ready <= 1'b0;
        if (push || timeout) begin
          state <= ST_IDLE;
        end else if (state == ST_WAIT) begin
          tmo_cnt <= tmo_cnt + TO_W'(1);
        end
      end
      if (timeout) begin
        req_timeout_err <= 1'b1;
      end
    end
  end

  // FIFO storage holds already-converted duty words; the head is read directly (fall-through).
  // NOTE: the data array has no reset; only pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= to_duty(s_if.sample[SAMPLE_W-1 -: PWM_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Free-running PWM counter; the duty register only changes on the last count of a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt       <= '0;
      duty          <= DUTY_MID;
      underflow_cnt <= '0;
      pwm           <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      pwm     <= (pwm_cnt < duty);
      if (boundary) begin
        if (!fifo_empty) begin
          duty <= mem[rd_ptr];
        end else begin
`ifdef SYNTH_PWM_UNDERFLOW_MUTE_EN
          duty <= DUTY_MID;
`else
          duty <= duty;
`endif
          if (underflow_cnt != 8'hFF) begin
            underflow_cnt <= underflow_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_synth_pwm_stream.sv
// Self-checking bench for synth_pwm_stream: synth response model, FIFO/duty scoreboard, corner sequences.
module tb_synth_pwm_stream;

  localparam int SAMPLE_W    = 14;
  localparam int PWM_W       = 10;
  localparam int FIFO_DEPTH  = 4;
  localparam int REQ_TIMEOUT = 4;
  localparam int PERIOD      = 1 << PWM_W;
  localparam int MID         = 1 << (PWM_W - 1);

  localparam logic [SAMPLE_W-1:0] DEF_S    = 14'h1000;
  localparam int                  DEF_DUTY = 768;
  localparam logic [SAMPLE_W-1:0] STRAY_S  = 14'h1FFF;

  typedef struct {
    logic [SAMPLE_W-1:0] s;
    int                  duty;
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       pwm;
  logic [2:0] fifo_level;
  logic [7:0] underflow_cnt;
  logic       req_timeout_err;

  synth_pwm_stream_if #(.SAMPLE_W(SAMPLE_W)) s_if ();

  synth_pwm_stream #(
    .SAMPLE_W   (SAMPLE_W),
    .PWM_W      (PWM_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .REQ_TIMEOUT(REQ_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .s_if           (s_if),
    .pwm            (pwm),
    .fifo_level     (fifo_level),
    .underflow_cnt  (underflow_cnt),
    .req_timeout_err(req_timeout_err)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  bit   resp_mode = 1'b1;
  bit   stray_valid = 1'b0;
  int   edge_cnt;
  int   pulse_cnt = 0;
  vec_t src_q[$];
  int   exp_q[$];
  int   cur_duty = MID;
  int   period_duty = MID;
  int   high_cnt = 0;
  int   exp_uf = 0;
  bit   pend = 1'b0;
  bit   ready_prev = 1'b0;
  bit   resp_now;
  vec_t v;
  int   pos;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (s_if.sample_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Posedges since reset release; equals the DUT PWM counter modulo PERIOD at each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // Synth model (answers a pulse one cycle later) plus FIFO/duty scoreboard, all on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cur_duty          = MID;
      period_duty       = MID;
      high_cnt          = 0;
      exp_uf            = 0;
      pend              = 1'b0;
      ready_prev        = 1'b0;
      s_if.sample_valid = 1'b0;
      s_if.sample       = '0;
    end else begin
      if (edge_cnt > 0) begin
        pos = (edge_cnt - 1) % PERIOD;
        if (pwm) high_cnt++;
        if (pos == 0 || pos == period_duty - 1 || pos == period_duty)
          check("pwm_phase", pwm, (pos < period_duty));
        if (pos == PERIOD - 1) begin
          check("pwm_high_cycles", high_cnt, period_duty);
          high_cnt    = 0;
          period_duty = cur_duty;
        end
      end
      check("fifo_level", fifo_level, exp_q.size());
      check("underflow_cnt", underflow_cnt, exp_uf);
      if (s_if.sample_ready) begin
        pulse_cnt++;
        check("ready_spacing", ready_prev, 0);
        check("ready_not_full", (exp_q.size() < FIFO_DEPTH), 1);
      end
      resp_now   = pend && resp_mode;
      ready_prev = s_if.sample_ready;
      pend       = s_if.sample_ready;
      if (resp_now) begin
        if (src_q.size() > 0) v = src_q.pop_front();
        else                  v = '{DEF_S, DEF_DUTY};
        s_if.sample = v.s;
      end else begin
        s_if.sample = stray_valid ? STRAY_S : '0;
      end
      s_if.sample_valid = resp_now || stray_valid;
      // Mirror the upcoming edge: pop (or underflow) first, then the push it carries.
      if (edge_cnt % PERIOD == PERIOD - 1) begin
        if (exp_q.size() > 0) begin
          cur_duty = exp_q.pop_front();
        end else begin
          if (exp_uf < 255) exp_uf++;
`ifdef SYNTH_PWM_UNDERFLOW_MUTE_EN
          cur_duty = MID;
`endif
        end
      end
      if (resp_now) exp_q.push_back(v.duty);
    end
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    vec_t vecs [9];
    bit   ok;
    int   p0;
    vecs[0] = '{14'h2000, 0};
    vecs[1] = '{14'h1FFF, 1023};
    vecs[2] = '{14'h0000, 512};
    vecs[3] = '{14'h3FFF, 511};
    vecs[4] = '{14'h1000, 768};
    vecs[5] = '{14'h3000, 256};
    vecs[6] = '{14'h0010, 513};
    vecs[7] = '{14'h000F, 512};
    vecs[8] = '{14'h2010, 1};

    // Reset with enable high: the request pulse must stay low.
    enable = 1'b1;
    tick(3);
    check("rst_sample_ready", s_if.sample_ready, 0);
    check("rst_pwm", pwm, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_underflow_cnt", underflow_cnt, 0);
    check("rst_timeout_err", req_timeout_err, 0);
    enable = 1'b0;
    foreach (vecs[i]) src_q.push_back(vecs[i]);
    #2 rst_n = 1'b1;
    tick(3);

    // First request one cycle after enable, then fill to full.
    @(posedge clk);
    #1 enable = 1'b1;
    @(negedge clk);
    check("ready_same_cycle", s_if.sample_ready, 0);
    @(negedge clk);
    check("ready_next_cycle", s_if.sample_ready, 1);
    tick(12);
    check("fill_level", fifo_level, FIFO_DEPTH);
    check("fill_pulses", pulse_cnt, FIFO_DEPTH);
    while (edge_cnt < PERIOD - 24) @(negedge clk);
    check("no_req_while_full", pulse_cnt, FIFO_DEPTH);
    while (edge_cnt < PERIOD + 8) @(negedge clk);
    check("req_after_first_pop", pulse_cnt, FIFO_DEPTH + 1);

    // Table vectors play out one per period; the scoreboard checks each duty.
    while (edge_cnt < 13 * PERIOD) @(negedge clk);
    check("table_consumed", src_q.size(), 0);

    // Drain with requests disabled, then underflow periods.
    enable = 1'b0;
    while (edge_cnt < 21 * PERIOD) @(negedge clk);
    check("drain_empty", fifo_level, 0);
    check("drain_underflowing", (underflow_cnt >= 8'd3), 1);

    // Silent synth: timeout after REQ_TIMEOUT wait cycles, immediate re-request.
    resp_mode = 1'b0;
    enable    = 1'b1;
    wait_ready(ok);
    check("timeout_req_seen", ok, 1);
    tick(3);
    check("timeout_err_early", req_timeout_err, 0);
    tick(1);
    check("timeout_err_set", req_timeout_err, 1);
    check("timeout_rerequest", s_if.sample_ready, 1);

    // Strobe while idle is ignored.
    enable = 1'b0;
    tick(8);
    stray_valid = 1'b1;
    tick(3);
    stray_valid = 1'b0;
    tick(2);
    check("idle_valid_ignored", fifo_level, 0);
    check("timeout_err_sticky", req_timeout_err, 1);

    // Dropping enable during WAIT keeps the pending capture.
    resp_mode = 1'b1;
    while (edge_cnt % PERIOD != 16) @(negedge clk);
    p0     = pulse_cnt;
    enable = 1'b1;
    wait_ready(ok);
    enable = 1'b0;
    check("disable_req_seen", ok, 1);
    tick(4);
    check("capture_after_disable", fifo_level, 1);
    check("single_request", pulse_cnt - p0, 1);

    // Refill, drain to level 3, then reset asynchronously mid-period.
    enable = 1'b1;
    tick(12);
    check("refill_level", fifo_level, FIFO_DEPTH);
    enable = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (fifo_level == 3'd3) begin
        ok = 1'b1;
        break;
      end
    end
    check("level3_reached", ok, 1);
    tick(100);
    check("pre_reset_pwm", pwm, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", pwm, 0);
    check("async_rst_ready", s_if.sample_ready, 0);
    check("async_rst_level", fifo_level, 0);
    check("async_rst_underflow", underflow_cnt, 0);
    check("async_rst_err", req_timeout_err, 0);
    tick(3);
    #2 rst_n = 1'b1;
    while (edge_cnt < 2 * PERIOD + 8) @(negedge clk);
    check("post_rst_underflow", underflow_cnt, 2);
    check("post_rst_ready", s_if.sample_ready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
